// File: rtl/constants.sv
// Shared RV32 decode constants and the decoded-instruction record used by the
// decode queue and the execute stage.
package constants;

    // Major opcodes (inst[6:0]); all legal 32-bit encodings end in 2'b11.
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct7 values that select base, alternate (sub/sra) and M-extension ops.
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // One fully decoded instruction as held in the queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decoded_inst_t;

    // Flags encodings that are not legal RV32I (plus M when enable_m is set).
    function automatic logic decode_illegal(input logic [31:0] inst, input logic enable_m);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        opc = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        ill = (inst[1:0] != 2'b11);
        case (opc)
            OPC_LOAD: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
            end
            OPC_MISC_MEM, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_SYSTEM: begin
            end
            OPC_OP_IMM: begin
                // Shift-immediates reuse funct7 as an encoding qualifier.
                if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
            end
            OPC_STORE: begin
                if (f3 >= 3'b011) ill = 1'b1;
            end
            OPC_OP: begin
                // Only add/sub and srl/sra have an alternate-funct7 form.
                if (f7 == F7_ALT && !(f3 == 3'b000 || f3 == 3'b101)) ill = 1'b1;
                if (f7 != F7_BASE && f7 != F7_ALT && !(enable_m && f7 == F7_MULDIV)) ill = 1'b1;
            end
            OPC_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
            end
            OPC_JALR: begin
                if (f3 != 3'b000) ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/immediate_generator.sv
// Combinational RV32 immediate extraction; formats chosen by opcode, unknown
// opcodes yield zero.
module immediate_generator
    import constants::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Select and sign-extend the immediate layout implied by the opcode.
    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_queue.sv
// Decodes fetched RV32 instructions and buffers the records in a DEPTH-entry
// FIFO for the execute stage. Flush drops everything, including a same-cycle push.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// in_ready depends only on the fill level (never on out_ready); out_* are
// stable while out_valid && !out_ready.
module instruction_decode_queue
    import constants::*;
#(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

    decoded_inst_t mem [DEPTH];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    cnt_t          count;

    decoded_inst_t dec;
    decoded_inst_t head;
    logic [31:0]   dec_imm;
    logic          push;
    logic          pop;

    immediate_generator u_immediate_generator (
        .inst (in_inst),
        .imm  (dec_imm)
    );

    // Build the record for the incoming instruction.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_inst[6:0];
        dec.funct3  = in_inst[14:12];
        dec.funct7  = in_inst[31:25];
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.imm     = dec_imm;
        dec.illegal = decode_illegal(in_inst, ENABLE_M);
    end

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != cnt_t'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer, count and storage update; flush wins over push and pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Bench for instruction_decode_queue: directed vectors, expected records queued
// at push time and checked by an output monitor.
module tb_instruction_decode_queue;

    localparam int W = 97;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main DUT (ENABLE_M = 1)
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic        out_illegal;

    // second DUT (ENABLE_M = 0)
    logic        n_flush = 1'b0;
    logic        n_in_valid = 1'b0;
    logic        n_in_ready;
    logic [31:0] n_in_inst = '0;
    logic [31:0] n_in_pc = '0;
    logic        n_out_valid;
    logic        n_out_ready = 1'b1;
    logic [31:0] n_out_pc;
    logic [6:0]  n_out_opcode;
    logic [2:0]  n_out_funct3;
    logic [6:0]  n_out_funct7;
    logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
    logic [31:0] n_out_imm;
    logic        n_out_illegal;

    instruction_decode_queue #(.DEPTH(2), .ENABLE_M(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    instruction_decode_queue #(.DEPTH(2), .ENABLE_M(1'b0)) dut_nom (
        .clock(clock), .reset(reset), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_inst(n_in_inst), .in_pc(n_in_pc),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_pc(n_out_pc),
        .out_opcode(n_out_opcode), .out_funct3(n_out_funct3), .out_funct7(n_out_funct7),
        .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2),
        .out_imm(n_out_imm), .out_illegal(n_out_illegal)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;
    int stalls  = 0;

    function automatic logic [W-1:0] pack_exp(input logic [31:0] pc, input logic [31:0] inst,
                                              input logic [31:0] imm, input logic ill);
        return {pc, inst[6:0], inst[14:12], inst[31:25], inst[11:7], inst[19:15],
                inst[24:20], imm, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    // Every accepted output is compared against the oldest expected record.
    always @(negedge clock) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (!reset && out_valid && out_ready) begin
            act = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                   out_imm, out_illegal};
            n_tests++;
            pops++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc=%h imm=%h, expected no output", out_pc, out_imm);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL pop_record: got %h expected %h (pc got %h exp %h)",
                             act, exp, act[W-1 -: 32], exp[W-1 -: 32]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_one(input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] imm, input logic ill);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        while (!in_ready && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        stalls += waited;
        exp_q.push_back(pack_exp(pc, inst, imm, ill));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pops_before;
        int cyc;

        // reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_fields", {out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                                 out_illegal}, 32'd0);

        // first push, one-cycle latency, fields decoded
        push_one(32'h00500093, 32'h0000_0000, 32'h0000_0005, 1'b0);
        check("lat_out_valid", {31'b0, out_valid}, 32'd1);
        check("addi_rd", {27'b0, out_rd}, 32'd1);
        check("addi_rs1", {27'b0, out_rs1}, 32'd0);
        check("addi_imm", out_imm, 32'h0000_0005);
        check("addi_illegal", {31'b0, out_illegal}, 32'd0);
        out_ready = 1'b1;

        // immediate formats and illegal flags (out_ready = 1)
        push_one(32'hFE000EE3, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0); // beq -4
        push_one(32'h800000EF, 32'h0000_0008, 32'hFFF0_0000, 1'b0); // jal
        push_one(32'h0040A103, 32'h0000_000C, 32'h0000_0004, 1'b0); // lw
        push_one(32'h0020A423, 32'h0000_0010, 32'h0000_0008, 1'b0); // sw
        push_one(32'h123450B7, 32'h0000_0014, 32'h1234_5000, 1'b0); // lui
        push_one(32'hFFFFF117, 32'h0000_0018, 32'hFFFF_F000, 1'b0); // auipc
        push_one(32'hFFF00093, 32'h0000_001C, 32'hFFFF_FFFF, 1'b0); // addi -1
        push_one(32'h02208033, 32'h0000_0020, 32'h0000_0000, 1'b0); // mul, M on
        push_one(32'h00000000, 32'h0000_0024, 32'h0000_0000, 1'b1); // all zero
        push_one(32'h00002063, 32'h0000_0028, 32'h0000_0000, 1'b1); // branch f3=010
        push_one(32'h40101093, 32'h0000_002C, 32'h0000_0401, 1'b1); // slli bad f7
        push_one(32'h40105093, 32'h0000_0030, 32'h0000_0401, 1'b0); // srai
        push_one(32'h40001033, 32'h0000_0034, 32'h0000_0000, 1'b1); // OP alt f7, f3=001
        push_one(32'h000010E7, 32'h0000_0038, 32'h0000_0000, 1'b1); // jalr f3=001
        push_one(32'h0020B423, 32'h0000_003C, 32'h0000_0008, 1'b1); // store f3=011
        push_one(32'h0040B103, 32'h0000_0040, 32'h0000_0004, 1'b1); // load f3=011
        push_one(32'h00000073, 32'h0000_0044, 32'h0000_0000, 1'b0); // ecall
        push_one(32'h0000000F, 32'h0000_0048, 32'h0000_0000, 1'b0); // fence
        push_one(32'h00000001, 32'h0000_004C, 32'h0000_0000, 1'b1); // low bits != 11
        tick();

        // M disabled on second instance
        n_in_valid = 1'b1;
        n_in_inst  = 32'h02208033;
        n_in_pc    = 32'h0000_0100;
        tick();
        check("nom_mul_valid", {31'b0, n_out_valid}, 32'd1);
        check("nom_mul_illegal", {31'b0, n_out_illegal}, 32'd1);
        n_in_inst = 32'h002080B3; // add
        n_in_pc   = 32'h0000_0104;
        tick();
        n_in_valid = 1'b0;
        check("nom_add_pc", n_out_pc, 32'h0000_0104);
        check("nom_add_illegal", {31'b0, n_out_illegal}, 32'd0);

        // backpressure: fill with out_ready low, then release
        out_ready = 1'b0;
        push_one(32'h00100113, 32'h0000_0200, 32'h0000_0001, 1'b0);
        push_one(32'h00200193, 32'h0000_0204, 32'h0000_0002, 1'b0);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid  = 1'b1;
        in_inst   = 32'h00300213;
        in_pc     = 32'h0000_0208;
        out_ready = 1'b1;
        #1;
        check("full_ready_indep", {31'b0, in_ready}, 32'd0);
        #1;
        push_one(32'h00300213, 32'h0000_0208, 32'h0000_0003, 1'b0);
        tick();
        tick();

        // flush while full with in_valid
        out_ready = 1'b0;
        push_one(32'h00400293, 32'h0000_0300, 32'h0000_0004, 1'b0);
        push_one(32'h00500313, 32'h0000_0304, 32'h0000_0005, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00600393;
        in_pc    = 32'h0000_0308;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_count", 32'(dut.count), 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);

        // flush with an acceptable same-cycle push
        push_one(32'h00700413, 32'h0000_0310, 32'h0000_0007, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00800493;
        in_pc    = 32'h0000_0314;
        check("flush_push_offered", {31'b0, in_ready}, 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush2_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        push_one(32'h00900513, 32'h0000_0320, 32'h0000_0009, 1'b0);
        tick();

        // continuous stream, one per cycle
        stalls      = 0;
        pops_before = pops;
        for (int i = 0; i < 20; i++) begin
            push_one({12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011}, 32'h0000_0400 + 32'(4 * i),
                     32'(i), 1'b0);
        end
        @(negedge clock); #1;
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_pops", 32'(pops - pops_before), 32'd20);
        tick();

        // reset mid-stream
        out_ready = 1'b0;
        push_one(32'h00A00593, 32'h0000_0500, 32'h0000_000A, 1'b0);
        check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_pc", out_pc, 32'd0);
        exp_q.delete();
        @(posedge clock); #1 reset = 1'b0;
        out_ready = 1'b1;
        push_one(32'h00B00613, 32'h0000_0600, 32'h0000_000B, 1'b0);

        // drain and report
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_decode_queue.md
# instruction_decode_queue

Registered, parametrised successor to the combinational instruction field splitter. It accepts 32-bit RV32 instructions with their PC over a valid/ready handshake and decodes all fields, including the sign-extended immediate and an illegal-instruction flag. Decoded records are buffered in a DEPTH-entry FIFO for the execute stage. It sits between instruction fetch and the register-read/execute stage, and supports pipeline flush on branch/trap redirect.

## Interface
- DEPTH, 2: FIFO entries; power of two, >= 2
- ENABLE_M, 1: 1 = OP opcode with funct7 0000001 is legal (M extension); 0 = illegal
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered entries and any same-cycle push
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept
- in_inst  in  32  instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_pc  out  32  PC of head
- out_opcode  out  7  inst[6:0]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / inst[19:15] / inst[24:20]
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  instruction is not a legal RV32I(+M) encoding

## Operation
- Push on in_valid && in_ready. Decode in_inst combinationally, then write the record at wr_ptr.
- Pop on out_valid && out_ready: advance rd_ptr.
- in_ready = (count != DEPTH). It must not depend on out_ready, so no combinational path from out_ready to in_ready.
- out_valid = (count != 0). Out_* fields come from the entry at rd_ptr.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- flush has highest priority. Next cycle: count = 0, pointers = 0, the same-cycle push is dropped and the pop is ignored. Storage contents are not cleared.
- Immediate formats:
  - I-type (0000011, 0010011, 1100111, 1110011): sext(inst[31:20])
  - S-type (0100011): sext({inst[31:25], inst[11:7]})
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}
  - J-type (1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
  - any other opcode: 0
- out_illegal = 1 when any of the following holds:
  - inst[1:0] != 11
  - opcode is not in {LOAD, MISC-MEM 0001111, OP-IMM, AUIPC, STORE, OP 0110011, LUI, BRANCH, JALR, JAL, SYSTEM}
  - BRANCH with funct3 in {010, 011}
  - LOAD with funct3 in {011, 110, 111}
  - STORE with funct3 >= 011
  - JALR with funct3 != 000
  - OP-IMM funct3 001 with funct7 != 0
  - OP-IMM funct3 101 with funct7 not in {0000000, 0100000}
  - OP with funct7 0100000 and funct3 not in {000, 101}
  - OP with funct7 not in {0000000, 0100000} and not (ENABLE_M && funct7 == 0000001)
- Illegal instructions are still queued; they are not dropped. Their imm follows the table above.

## Timing
- Reset state: count = 0, pointers = 0, all storage = 0. Outputs are in_ready = 1, out_valid = 0, all out_* data = 0.
- Reset is asserted asynchronously and released synchronously by the integrator. Reset mid-stream empties the queue immediately.
- Latency is 1 cycle: an instruction pushed in cycle N appears on out_* with out_valid = 1 in cycle N+1. There is no bypass when empty.
- Full-rate throughput is one instruction per cycle when out_ready is held at 1.
- When full, in_ready = 0 even if out_ready = 1 in the same cycle. The freed slot appears next cycle.
- Out_* fields hold stable while out_valid && !out_ready.

## Structure
- Opcode constants and the decoded_inst_t packed struct belong in constants.sv. The struct holds pc, opcode, funct3, funct7, rd, rs1, rs2, imm and illegal.
- Sub-module: immediate_generator, a combinational inst-to-imm block that the execute stage will reuse.
- FIFO storage is an array of decoded_inst_t, owned by this module.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) at PC 0x0 → next cycle out_valid = 1, rd = 1, rs1 = 0, imm = 0x00000005, illegal = 0.
- Push 0xFE000EE3 (beq x0,x0,-4) → imm = 0xFFFFFFFC. Push 0x800000EF (jal) → imm = 0xFFF00000.
- Hold out_ready = 0 and push 3 instructions with DEPTH = 2 → in_ready = 0 after the 2nd push. Raise out_ready → entries come out in order, and in_ready returns the cycle after the first pop.
- Push 0x02208033 (mul): ENABLE_M = 1 → illegal = 0; ENABLE_M = 0 → illegal = 1. Push 0x00000000 → illegal = 1.
- Fill the queue, then assert flush together with in_valid → next cycle out_valid = 0, count = 0, and the flushed-cycle instruction is never output.
- Run a continuous stream with out_ready = 1 for 20 cycles → one output per cycle, pointers wrap, PC order preserved. Assert reset mid-stream → out_valid drops to 0 immediately.
